omsp_io_turnaround_ctrl: RTL and testbench
==========================================

// Module: omsp_io_turnaround_ctrl
//
// PURPOSE
//   Sequences a WIDTH-bit bidirectional pad group built from the tristate output and input buffer primitives.
//   Arbitrates between one write requester and one read requester.
//   Guarantees a minimum drive hold and a bus-turnaround gap after every drive.
//   Samples pads through a synchronizer before data is returned.
//   Sits between a peripheral (e.g. GPIO / parallel-bus port) and the pad buffers.
//
// PARAMETERS
//   WIDTH        8   pad group width, >=1
//   HOLD_CYC     2   cycles pad_oe stays high per write, >=1
//   TURN_CYC     2   cycles pad_oe held low after a write before next grant, >=0
//   SYNC_STAGES  2   pad_i synchronizer depth and read sample wait, >=1
//
// PORTS
//   mclk      in   1      system clock, all logic on rising edge
//   puc_rst   in   1      synchronous, active-high reset
//   wr_req    in   1      write request, level
//   wr_data   in   WIDTH  data to drive, captured on grant
//   wr_ack    out  1      1-cycle pulse: write granted, wr_data captured
//   rd_req    in   1      read request, level
//   rd_data   out  WIDTH  synchronized pad value, valid with rd_valid
//   rd_valid  out  1      1-cycle pulse: rd_data updated
//   busy      out  1      high whenever state != IDLE
//   pad_o     out  WIDTH  to output buffer data input
//   pad_oe    out  1      to output buffer enable; 1 = drive, 0 = hi-Z
//   pad_i     in   WIDTH  from input buffer outputs (asynchronous)
//
// BEHAVIOUR
// - Reset
//   - puc_rst sampled high -> state=IDLE at that edge.
//   - Same edge clears: pad_oe=0, pad_o=0, wr_ack=0, rd_valid=0, rd_data=0, counter=0.
//   - Same edge clears all synchronizer flops and sets last_grant=READ.
//   - Applies mid-transaction: the drive is aborted, no ack/valid is produced, and pad_oe drops on that edge.
// - Synchronizer
//   - SYNC_STAGES flops clocked every cycle, independent of state.
//   - sync_q is the last stage.
// - FSM states
//   - IDLE
//     - pad_oe=0.
//     - Only wr_req alone -> DRIVE.
//     - Only rd_req alone -> SAMPLE.
//     - Both high -> grant the type opposite last_grant (round-robin), so the first contention after reset goes to write.
//     - On write grant: wr_ack=1 for that cycle, pad_o<=wr_data, last_grant<=WRITE, cnt<=HOLD_CYC-1.
//     - On read grant: last_grant<=READ, cnt<=SYNC_STAGES-1.
//   - DRIVE
//     - pad_oe=1 (registered; high from the cycle after grant).
//     - cnt==0 -> TURN (cnt<=TURN_CYC-1) if TURN_CYC>0, else IDLE.
//     - Otherwise cnt-=1.
//     - pad_oe is high for exactly HOLD_CYC cycles.
//   - TURN
//     - pad_oe=0, with pad_o held.
//     - cnt==0 -> IDLE, otherwise cnt-=1.
//     - Exactly TURN_CYC cycles in TURN.
//   - SAMPLE
//     - pad_oe=0.
//     - cnt==0 -> IDLE with rd_data<=sync_q and rd_valid=1 the following cycle.
//     - Otherwise cnt-=1.
// - Latency
//   - Write: busy for HOLD_CYC+TURN_CYC cycles after the grant cycle.
//   - Read: rd_valid asserts SYNC_STAGES+1 cycles after the grant cycle.
//   - The read grant can only occur in IDLE, so turnaround after any drive is always complete before sampling.
// - Handshake
//   - Requests are ignored outside IDLE; a request held through busy is granted on return to IDLE.
//   - Requester deasserts after wr_ack / rd_valid; a request still held is treated as a new transaction.
//   - The first IDLE cycle after a transaction may grant immediately (no extra idle cycle).
//   - wr_data changes after wr_ack do not affect pad_o.
//   - rd_data holds its value until the next rd_valid.
// - Counter width: clog2 of max(HOLD_CYC, TURN_CYC, SYNC_STAGES)+1, no wrap.
// - Invariant: pad_oe never high outside DRIVE.
//
// TESTING
//   1. Reset
//      - Stimulus: hold puc_rst 3 cycles with pad_i=8'hFF.
//      - Required: pad_oe=0, pad_o=0, rd_data=0, busy=0, no pulses.
//   2. Single write
//      - Stimulus: wr_req=1, wr_data=8'hA5.
//      - Required: wr_ack in grant cycle; pad_oe=1 with pad_o=A5 for exactly 2 cycles; then 2 turn cycles; busy low at grant+5.
//   3. Single read
//      - Stimulus: pad_i=8'h3C stable, rd_req=1.
//      - Required: rd_valid pulse at grant+3; rd_data=3C; pad_oe stays 0 throughout.
//   4. Contention
//      - Stimulus: wr_req=rd_req=1 held for three transactions.
//      - Required: grant order write, read, write.
//      - Required: no read grant while pad_oe=1 or during TURN.
//   5. Reset mid-drive
//      - Stimulus: assert puc_rst in the 1st DRIVE cycle.
//      - Required: pad_oe=0 next edge; state IDLE; no rd_valid; the following write completes normally.
//   6. TURN_CYC=0, HOLD_CYC=1
//      - Stimulus: back-to-back writes.
//      - Required: pad_oe high 1 cycle, low 1 cycle (IDLE/grant), repeating.

Source files
------------

// File: rtl/omsp_io_turnaround_ctrl_if.sv
// rtl/omsp_io_turnaround_ctrl_if.sv - requester and pad-side signal bundle for the pad turnaround controller
interface omsp_io_turnaround_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic [WIDTH-1:0] pad_o;
  logic             pad_oe;
  logic [WIDTH-1:0] pad_i;

  modport slave (
    input  wr_req, wr_data, rd_req, pad_i,
    output wr_ack, rd_data, rd_valid, busy, pad_o, pad_oe
  );

  modport master (
    output wr_req, wr_data, rd_req, pad_i,
    input  wr_ack, rd_data, rd_valid, busy, pad_o, pad_oe
  );
endinterface

// File: rtl/omsp_io_turnaround_ctrl.sv
// rtl/omsp_io_turnaround_ctrl.sv - bidirectional pad group sequencer with drive hold, turnaround gap and synchronized reads
module omsp_io_turnaround_ctrl #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYC    = 2,
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      mclk,
  input  logic                      puc_rst,
  omsp_io_turnaround_ctrl_if.slave  bus
);

  localparam int MAX_HT  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int MAX_CYC = (MAX_HT > SYNC_STAGES) ? MAX_HT : SYNC_STAGES;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TURN_LOAD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam logic [CW-1:0] SYNC_LOAD = CW'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             grant_wr, grant_rd, rd_done;
  logic             last_wr;
  logic [WIDTH-1:0] pad_o_q;
  logic             pad_oe_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];

  // Pad input synchronizer, free-running regardless of the sequencer state
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= bus.pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Next-state, counter and grant decode; contention is round-robin against the last grant
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    rd_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!puc_rst) begin
          grant_wr = bus.wr_req && (!bus.rd_req || !last_wr);
          grant_rd = bus.rd_req && (!bus.wr_req || last_wr);
        end
        if (grant_wr) begin
          state_n = DRIVE;
          cnt_n   = HOLD_LOAD;
        end else if (grant_rd) begin
          state_n = SAMPLE;
          cnt_n   = SYNC_LOAD;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          if (TURN_CYC > 0) begin
            state_n = TURN;
            cnt_n   = TURN_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      TURN: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      SAMPLE: begin
        if (cnt == '0) begin
          state_n = IDLE;
          rd_done = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter and registered pad/read outputs; reset aborts any drive on the same edge
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_wr    <= 1'b0;
      pad_o_q    <= '0;
      pad_oe_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pad_oe_q   <= (state_n == DRIVE);
      rd_valid_q <= rd_done;
      if (grant_wr) begin
        pad_o_q <= bus.wr_data;
        last_wr <= 1'b1;
      end else if (grant_rd) begin
        last_wr <= 1'b0;
      end
      if (rd_done) rd_data_q <= sync_r[SYNC_STAGES-1];
    end
  end

  assign bus.wr_ack   = grant_wr;
  assign bus.busy     = (state != IDLE);
  assign bus.pad_o    = pad_o_q;
  assign bus.pad_oe   = pad_oe_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_omsp_io_turnaround_ctrl.sv
// tb/tb_omsp_io_turnaround_ctrl.sv - self-checking bench for the pad turnaround controller
module tb_omsp_io_turnaround_ctrl;

  localparam int HOLD = 2;
  localparam int TURN = 2;
  localparam int SYNC = 2;

  logic mclk;
  logic puc_rst;
  int   cyc;
  int   n_pass;
  int   n_total;

  omsp_io_turnaround_ctrl_if #(.WIDTH(8)) bus ();
  omsp_io_turnaround_ctrl_if #(.WIDTH(8)) bus2 ();

  omsp_io_turnaround_ctrl #(.WIDTH(8), .HOLD_CYC(HOLD), .TURN_CYC(TURN), .SYNC_STAGES(SYNC)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (bus)
  );

  omsp_io_turnaround_ctrl #(.WIDTH(8), .HOLD_CYC(1), .TURN_CYC(0), .SYNC_STAGES(2)) dut2 (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (bus2)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  always @(posedge mclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else n_pass++;
  endtask

  task automatic next();
    @(posedge mclk);
    #1;
  endtask

  // Timeline reference model: each grant opens fixed windows of drive, busy and read-valid
  bit         m_en;
  int         busy_end, drv_lo, drv_hi, rv_cycle;
  bit         m_last_wr;
  logic [7:0] m_pad_o, m_rd_data, rv_data;

  always @(negedge mclk) begin
    bit idle, wg, rg;
    idle = 1'b0; wg = 1'b0; rg = 1'b0;
    if (m_en) begin
      if (cyc == rv_cycle) m_rd_data = rv_data;
      idle = (cyc >= busy_end);
      wg = idle && !puc_rst && bus.wr_req && (!bus.rd_req || !m_last_wr);
      rg = idle && !puc_rst && bus.rd_req && !wg;
      check("m_busy",     bus.busy,     !idle);
      check("m_pad_oe",   bus.pad_oe,   (cyc >= drv_lo) && (cyc <= drv_hi));
      check("m_wr_ack",   bus.wr_ack,   wg);
      check("m_rd_valid", bus.rd_valid, cyc == rv_cycle);
      check("m_pad_o",    bus.pad_o,    m_pad_o);
      check("m_rd_data",  bus.rd_data,  m_rd_data);
    end
    if (puc_rst) begin
      m_en      = 1'b1;
      busy_end  = cyc + 1;
      drv_lo    = -10;
      drv_hi    = -10;
      rv_cycle  = -10;
      m_last_wr = 1'b0;
      m_pad_o   = 8'h00;
      m_rd_data = 8'h00;
    end else if (m_en) begin
      if (wg) begin
        m_last_wr = 1'b1;
        m_pad_o   = bus.wr_data;
        drv_lo    = cyc + 1;
        drv_hi    = cyc + HOLD;
        busy_end  = cyc + HOLD + TURN + 1;
      end else if (rg) begin
        m_last_wr = 1'b0;
        rv_cycle  = cyc + SYNC + 1;
        rv_data   = bus.pad_i;
        busy_end  = cyc + SYNC + 1;
      end
    end
  end

  task automatic do_write(input logic [7:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_data = d;
    @(negedge mclk);
    check("wr_ack_grant", bus.wr_ack, 1'b1);
    next();
    bus.wr_req  = 1'b0;
    bus.wr_data = ~d;
    for (int k = 1; k <= 5; k++) begin
      @(negedge mclk);
      check("wr_pad_oe", bus.pad_oe, k <= HOLD);
      check("wr_busy",   bus.busy,   k <= HOLD + TURN);
      if (k <= 4) check("wr_pad_o", bus.pad_o, d);
      if (k < 5) next();
    end
  endtask

  task automatic do_read(input logic [7:0] d);
    bus.pad_i  = d;
    bus.rd_req = 1'b1;
    @(negedge mclk);
    check("rd_grant_idle", bus.busy, 1'b0);
    next();
    bus.rd_req = 1'b0;
    bus.pad_i  = ~d;
    for (int k = 1; k <= 3; k++) begin
      @(negedge mclk);
      check("rd_valid_time", bus.rd_valid, k == 3);
      check("rd_pad_oe", bus.pad_oe, 1'b0);
      if (k == 3) check("rd_data", bus.rd_data, d);
      if (k < 3) next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit   kind_w [3];
    int   gcyc [3];
    int   ng;
    n_pass = 0; n_total = 0; cyc = 0; m_en = 1'b0;
    puc_rst = 1'b1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_data = 8'h00; bus.pad_i = 8'hFF;
    bus2.wr_req = 1'b0; bus2.rd_req = 1'b0; bus2.wr_data = 8'h00; bus2.pad_i = 8'h00;

    // Reset held three cycles with pads high
    repeat (2) next();
    @(negedge mclk);
    check("rst_pad_oe",   bus.pad_oe,   1'b0);
    check("rst_pad_o",    bus.pad_o,    8'h00);
    check("rst_rd_data",  bus.rd_data,  8'h00);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_wr_ack",   bus.wr_ack,   1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    next();
    puc_rst = 1'b0;

    // Single write then single read
    do_write(8'hA5);
    next();
    do_read(8'h3C);

    // Contention: both requests held for three grants
    next();
    bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.wr_data = 8'h11;
    ng = 0;
    for (int t = 0; t < 40 && ng < 3; t++) begin
      @(negedge mclk);
      if (!bus.busy) begin
        kind_w[ng] = bus.wr_ack;
        gcyc[ng]   = cyc;
        if (!bus.wr_ack) check("rd_grant_no_drive", bus.pad_oe, 1'b0);
        ng++;
      end
      if (ng < 3) next();
    end
    next();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check("cont_grants", ng, 3);
    if (ng == 3) begin
      check("cont_order0", kind_w[0], 1'b1);
      check("cont_order1", kind_w[1], 1'b0);
      check("cont_order2", kind_w[2], 1'b1);
      check("cont_gap_wr", gcyc[1] - gcyc[0], HOLD + TURN + 1);
      check("cont_gap_rd", gcyc[2] - gcyc[1], SYNC + 1);
    end

    // Reset in the first drive cycle, then a normal write
    repeat (6) next();
    bus.wr_req = 1'b1; bus.wr_data = 8'h5A;
    @(negedge mclk);
    check("mid_ack", bus.wr_ack, 1'b1);
    next();
    puc_rst = 1'b1; bus.wr_req = 1'b0;
    @(negedge mclk);
    check("mid_oe_before", bus.pad_oe, 1'b1);
    next();
    puc_rst = 1'b0;
    @(negedge mclk);
    check("mid_oe_after", bus.pad_oe, 1'b0);
    check("mid_busy",     bus.busy,   1'b0);
    check("mid_pad_o",    bus.pad_o,  8'h00);
    for (int k = 0; k < 3; k++) begin
      next();
      @(negedge mclk);
      check("mid_no_valid", bus.rd_valid, 1'b0);
    end
    next();
    do_write(8'hC3);

    // Randomized traffic with occasional resets
    for (int t = 0; t < 1500; t++) begin
      next();
      puc_rst     = ($urandom_range(0, 99) == 0);
      bus.wr_req  = ($urandom_range(0, 2) == 0);
      bus.rd_req  = ($urandom_range(0, 2) == 0);
      bus.wr_data = 8'($urandom);
      bus.pad_i   = 8'($urandom);
    end
    next();
    puc_rst = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    repeat (8) next();

    // Zero turnaround, single-cycle hold: back-to-back writes alternate drive and grant
    bus2.wr_req = 1'b1; bus2.wr_data = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge mclk);
      check("t6_wr_ack", bus2.wr_ack, (i % 2) == 0);
      check("t6_pad_oe", bus2.pad_oe, (i % 2) == 1);
      check("t6_busy",   bus2.busy,   (i % 2) == 1);
      if (i % 2 == 1) check("t6_pad_o", bus2.pad_o, 8'h10 + 8'(i - 1));
      next();
      bus2.wr_data = 8'h10 + 8'(i + 1);
    end
    bus2.wr_req = 1'b0;
    next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
